// File: rtl/hiscore_ram_responder.sv
// ============================================================================
// Module      : hiscore_ram_responder
// Description : Takes the work RAM from the Z80 via BUSRQ/BUSAK and services
//               hiscore save/restore reads and writes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hiscore_ram_responder #(
  parameter logic [15:0] RAM_BASE      = 16'h6000,
  parameter int          RAM_AW        = 12,
  parameter int          BUSAK_TIMEOUT = 255
) (
  input  logic              I_CLK_24576M,
  input  logic              I_RESETn,
  input  logic              hs_access,
  input  logic [15:0]       hs_address,
  input  logic [7:0]        hs_data_in,
  input  logic              hs_write,
  output logic [7:0]        hs_data_out,
  input  logic [RAM_AW-1:0] cpu_addr,
  input  logic [7:0]        cpu_dout,
  input  logic              cpu_ram_we,
  output logic              O_BUSRQn,
  input  logic              I_BUSAKn,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [7:0]        ram_din,
  output logic              ram_we,
  input  logic [7:0]        ram_dout,
  output logic              o_grant,
  output logic              o_timeout
);

  localparam int              CW          = (BUSAK_TIMEOUT < 1) ? 1 : $clog2(BUSAK_TIMEOUT + 1);
  localparam logic [CW-1:0]   C_TIMEOUT   = CW'(BUSAK_TIMEOUT);
  localparam logic [16:0]     C_WIN_SIZE  = 17'd1 << RAM_AW;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_GRANT   = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              w_set_timeout;
  logic              w_busrq_n;
  logic              w_grant;

  logic              r_busak_s1;
  logic              r_busak_s2;
  logic [CW-1:0]     r_cnt;
  logic              r_timeout;

  logic [15:0]       w_offset;
  logic              w_in_win;

  logic [RAM_AW-1:0] r_hs_addr;
  logic [7:0]        r_hs_data;
  logic              r_hs_we;
  logic              r_hs_rd;
  logic              r_hs_v1;
  logic              r_hs_rd_d;
  logic              r_hs_v2;
  logic [7:0]        r_hs_dout;

  // Unsigned wrap makes addresses below RAM_BASE land far outside the window.
  assign w_offset = hs_address - RAM_BASE;
  assign w_in_win = ({1'b0, w_offset} < C_WIN_SIZE);

  always_ff @(posedge I_CLK_24576M) begin
    if (!I_RESETn) begin
      r_busak_s1 <= 1'b1;
      r_busak_s2 <= 1'b1;
    end else begin
      r_busak_s1 <= I_BUSAKn;
      r_busak_s2 <= r_busak_s1;
    end
  end

  always_ff @(posedge I_CLK_24576M) begin
    if (!I_RESETn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Dropping hs_access wins over a BUSAK that arrives in the same clock.
  always_comb begin
    w_state_nxt   = r_state;
    w_set_timeout = 1'b0;
    w_busrq_n     = 1'b0;
    w_grant       = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_busrq_n = 1'b1;
        if (hs_access) begin
          w_state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        if (!hs_access) begin
          w_state_nxt = S_IDLE;
        end else if (!r_busak_s2) begin
          w_state_nxt = S_GRANT;
        end else if (r_cnt == C_TIMEOUT) begin
          w_state_nxt   = S_GRANT;
          w_set_timeout = 1'b1;
        end
      end
      S_GRANT: begin
        w_grant = 1'b1;
        if (!hs_access) begin
          w_state_nxt = S_RELEASE;
        end
      end
      S_RELEASE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_busrq_n   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge I_CLK_24576M) begin
    if (!I_RESETn) begin
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      if ((r_state == S_REQ) && (w_state_nxt == S_REQ)) begin
        r_cnt <= r_cnt + 1'b1;
      end else begin
        r_cnt <= '0;
      end
      if (w_set_timeout) begin
        r_timeout <= 1'b1;
      end
    end
  end

  // Three-stage access pipeline; valid bits keep hs_data_out from being
  // overwritten by stale stages in the first clocks of a fresh grant.
  always_ff @(posedge I_CLK_24576M) begin
    if (!I_RESETn) begin
      r_hs_addr <= '0;
      r_hs_data <= 8'h00;
      r_hs_we   <= 1'b0;
      r_hs_rd   <= 1'b0;
      r_hs_v1   <= 1'b0;
      r_hs_rd_d <= 1'b0;
      r_hs_v2   <= 1'b0;
      r_hs_dout <= 8'hFF;
    end else begin
      if (w_grant) begin
        r_hs_addr <= hs_address[RAM_AW-1:0];
        r_hs_data <= hs_data_in;
        r_hs_we   <= hs_write & w_in_win;
        r_hs_rd   <= w_in_win & ~hs_write;
        r_hs_v1   <= 1'b1;
      end else begin
        r_hs_we   <= 1'b0;
        r_hs_v1   <= 1'b0;
      end
      r_hs_rd_d <= r_hs_rd;
      r_hs_v2   <= r_hs_v1 & w_grant;
      if (w_grant && r_hs_v2) begin
        r_hs_dout <= r_hs_rd_d ? ram_dout : 8'hFF;
      end
    end
  end

  always_comb begin
    ram_addr = cpu_addr;
    ram_din  = cpu_dout;
    ram_we   = cpu_ram_we;
    if (w_grant) begin
      ram_addr = r_hs_addr;
      ram_din  = r_hs_data;
      ram_we   = r_hs_we;
    end
  end

  assign O_BUSRQn    = w_busrq_n;
  assign o_grant     = w_grant;
  assign o_timeout   = r_timeout;
  assign hs_data_out = r_hs_dout;

endmodule

`default_nettype wire

// File: tb/tb_hiscore_ram_responder.sv
// ============================================================================
// Module      : tb_hiscore_ram_responder
// Description : Directed self-checking bench with a per-cycle reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hiscore_ram_responder;

  logic        clk = 1'b0;
  logic        I_RESETn;
  logic        hs_access;
  logic [15:0] hs_address;
  logic [7:0]  hs_data_in;
  logic        hs_write;
  logic [7:0]  hs_data_out;
  logic [11:0] cpu_addr;
  logic [7:0]  cpu_dout;
  logic        cpu_ram_we;
  logic        O_BUSRQn;
  logic        I_BUSAKn;
  logic [11:0] ram_addr;
  logic [7:0]  ram_din;
  logic        ram_we;
  logic [7:0]  ram_dout;
  logic        o_grant;
  logic        o_timeout;

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0] mem     [0:4095];
  logic [7:0] ref_mem [0:4095];

  typedef struct packed {
    logic        g;
    logic        rn;
    logic        acc;
    logic        wr;
    logic [15:0] a;
    logic [7:0]  d;
    logic [7:0]  hdo;
    logic        to;
  } snap_t;

  snap_t h [0:4];

  always #5 clk = ~clk;

  hiscore_ram_responder #(
    .RAM_BASE      (16'h6000),
    .RAM_AW        (12),
    .BUSAK_TIMEOUT (255)
  ) dut (
    .I_CLK_24576M (clk),
    .I_RESETn     (I_RESETn),
    .hs_access    (hs_access),
    .hs_address   (hs_address),
    .hs_data_in   (hs_data_in),
    .hs_write     (hs_write),
    .hs_data_out  (hs_data_out),
    .cpu_addr     (cpu_addr),
    .cpu_dout     (cpu_dout),
    .cpu_ram_we   (cpu_ram_we),
    .O_BUSRQn     (O_BUSRQn),
    .I_BUSAKn     (I_BUSAKn),
    .ram_addr     (ram_addr),
    .ram_din      (ram_din),
    .ram_we       (ram_we),
    .ram_dout     (ram_dout),
    .o_grant      (o_grant),
    .o_timeout    (o_timeout)
  );

  // Synchronous work RAM with one clock of read latency.
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  function automatic logic in_win(input logic [15:0] a);
    logic [15:0] off;
    off = a - 16'h6000;
    return off < 16'h1000;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic hs_set(input logic [15:0] a, input logic [7:0] d, input logic wr);
    hs_address = a;
    hs_data_in = d;
    hs_write   = wr;
  endtask

  // Per-cycle model: compares outputs against rules applied to the input history.
  initial begin
    logic       ew;
    logic [7:0] er;
    for (int k = 0; k < 5; k++) h[k] = '0;
    forever begin
      @(negedge clk);
      for (int k = 4; k > 0; k--) h[k] = h[k-1];
      h[0] = '{g: o_grant, rn: I_RESETn, acc: hs_access, wr: hs_write, a: hs_address,
               d: hs_data_in, hdo: hs_data_out, to: o_timeout};
      if (!o_grant) begin
        chk("cpu_mux", {ram_we, ram_din, ram_addr}, {cpu_ram_we, cpu_dout, cpu_addr});
      end else begin
        chk("grant_busrq", O_BUSRQn, 1'b0);
        if (h[1].g && h[1].rn) begin
          ew = h[1].wr & in_win(h[1].a);
          chk("hs_we", ram_we, ew);
          chk("hs_addr", ram_addr, h[1].a[11:0]);
          if (ew) chk("hs_din", ram_din, h[1].d);
        end else begin
          chk("first_grant_we", ram_we, 1'b0);
        end
      end
      if (h[1].g && h[2].g && h[3].g && h[4].g && h[1].rn && h[2].rn && h[3].rn && h[4].rn &&
          !h[3].wr && !h[4].wr && (h[3].a == h[4].a)) begin
        er = in_win(h[3].a) ? ref_mem[h[3].a[11:0]] : 8'hFF;
        chk("read_data", hs_data_out, er);
      end
      if (!h[1].g && h[1].rn) chk("dout_hold", hs_data_out, h[1].hdo);
      if (h[1].to && h[1].rn) chk("timeout_sticky", o_timeout, 1'b1);
    end
  end

  initial begin
    int cnt_edges;
    logic got;
    for (int i = 0; i < 4096; i++) ref_mem[i] = 8'h00;
    I_RESETn = 1'b0; hs_access = 1'b0; hs_set(16'h0000, 8'h00, 1'b0);
    cpu_addr = 12'h000; cpu_dout = 8'h00; cpu_ram_we = 1'b0; I_BUSAKn = 1'b1;
    repeat (3) tick();
    I_RESETn = 1'b1;
    tick();
    chk("rst_busrq", O_BUSRQn, 1'b1);
    chk("rst_grant", o_grant, 1'b0);
    chk("rst_timeout", o_timeout, 1'b0);
    chk("rst_dout", hs_data_out, 8'hFF);
    cpu_addr = 12'h123; cpu_dout = 8'h5A; cpu_ram_we = 1'b1;
    #1;
    chk("idle_ram_addr", ram_addr, 12'h123);
    chk("idle_ram_we", ram_we, 1'b1);
    chk("idle_ram_din", ram_din, 8'h5A);
    tick();
    ref_mem[12'h123] = 8'h5A;
    cpu_ram_we = 1'b0;

    // Grant via BUSAK; first edge that samples it, then two more clocks.
    hs_access = 1'b1;
    repeat (5) tick();
    chk("req_busrq", O_BUSRQn, 1'b0);
    I_BUSAKn = 1'b0;
    tick(); chk("grant_sync1", o_grant, 1'b0);
    tick(); chk("grant_sync2", o_grant, 1'b0);
    tick(); chk("grant_rise", o_grant, 1'b1);

    hs_set(16'h6010, 8'hA5, 1'b1);
    tick();
    chk("wr_we", ram_we, 1'b1);
    chk("wr_addr", ram_addr, 12'h010);
    chk("wr_din", ram_din, 8'hA5);
    repeat (3) tick();
    ref_mem[12'h010] = 8'hA5;

    cpu_addr = 12'h300; cpu_dout = 8'hEE; cpu_ram_we = 1'b1;
    hs_set(16'h6010, 8'h00, 1'b0);
    tick(); tick();
    chk("rd_lat2", hs_data_out, 8'hFF);
    tick();
    chk("rd_6010", hs_data_out, 8'hA5);
    chk("cpu_blocked", ram_we, 1'b0);
    tick();
    cpu_ram_we = 1'b0;

    hs_set(16'h7000, 8'h00, 1'b0);
    repeat (3) tick();
    chk("rd_7000", hs_data_out, 8'hFF);
    tick();
    hs_set(16'h5FFF, 8'h3C, 1'b1);
    tick();
    chk("wr_5fff_we", ram_we, 1'b0);
    repeat (3) tick();
    hs_set(16'h6000, 8'h11, 1'b1);
    tick();
    chk("wr_6000_we", ram_we, 1'b1);
    chk("wr_6000_addr", ram_addr, 12'h000);
    repeat (3) tick();
    ref_mem[12'h000] = 8'h11;
    hs_set(16'h6FFF, 8'h22, 1'b1);
    tick();
    chk("wr_6fff_we", ram_we, 1'b1);
    chk("wr_6fff_addr", ram_addr, 12'hFFF);
    repeat (3) tick();
    ref_mem[12'hFFF] = 8'h22;
    hs_set(16'h6000, 8'h00, 1'b0);
    repeat (3) tick();
    chk("rd_6000", hs_data_out, 8'h11);
    tick();
    hs_set(16'h6FFF, 8'h00, 1'b0);
    repeat (3) tick();
    chk("rd_6fff", hs_data_out, 8'h22);
    tick();
    hs_set(16'h5FFF, 8'h00, 1'b0);
    repeat (3) tick();
    chk("rd_5fff", hs_data_out, 8'hFF);
    tick();

    // Release: one RELEASE clock with BUSRQ still low.
    hs_access = 1'b0;
    tick();
    chk("rel_grant", o_grant, 1'b0);
    chk("rel_busrq", O_BUSRQn, 1'b0);
    tick();
    chk("rel_idle_busrq", O_BUSRQn, 1'b1);
    I_BUSAKn = 1'b1;
    cpu_addr = 12'h200; cpu_dout = 8'h77; cpu_ram_we = 1'b1;
    #1;
    chk("rel_cpu_we", ram_we, 1'b1);
    chk("rel_cpu_addr", ram_addr, 12'h200);
    tick();
    ref_mem[12'h200] = 8'h77;
    cpu_ram_we = 1'b0;
    repeat (2) tick();

    // Abort during REQ.
    hs_access = 1'b1;
    tick(); chk("abort_req_busrq", O_BUSRQn, 1'b0);
    tick(); tick();
    hs_access = 1'b0;
    chk("abort_hold_busrq", O_BUSRQn, 1'b0);
    tick();
    chk("abort_busrq", O_BUSRQn, 1'b1);
    chk("abort_grant", o_grant, 1'b0);
    repeat (2) tick();

    // Timeout with BUSAK never asserted.
    hs_access = 1'b1;
    cnt_edges = 0;
    got = 1'b0;
    for (int k = 0; k < 400 && !got; k++) begin
      tick();
      cnt_edges++;
      if (cnt_edges == 256) begin
        chk("pre_to_grant", o_grant, 1'b0);
        chk("pre_to_flag", o_timeout, 1'b0);
      end
      if (o_grant) got = 1'b1;
    end
    chk("to_latency", cnt_edges, 257);
    chk("to_flag", o_timeout, 1'b1);
    repeat (2) tick();
    hs_access = 1'b0;
    repeat (4) tick();
    chk("to_sticky_idle", o_timeout, 1'b1);
    chk("to_idle_busrq", O_BUSRQn, 1'b1);
    I_RESETn = 1'b0;
    tick();
    I_RESETn = 1'b1;
    chk("to_cleared", o_timeout, 1'b0);
    tick();

    // Reset while granted with a write in progress.
    hs_access = 1'b1; I_BUSAKn = 1'b0;
    repeat (4) tick();
    chk("rg_grant", o_grant, 1'b1);
    hs_set(16'h6020, 8'h99, 1'b1);
    tick();
    chk("rg_we", ram_we, 1'b1);
    ref_mem[12'h020] = 8'h99;
    I_RESETn = 1'b0;
    tick();
    chk("rg_rst_we", ram_we, 1'b0);
    chk("rg_rst_grant", o_grant, 1'b0);
    chk("rg_rst_busrq", O_BUSRQn, 1'b1);
    I_RESETn = 1'b1; hs_access = 1'b0; I_BUSAKn = 1'b1;
    hs_set(16'h0000, 8'h00, 1'b0);
    repeat (3) tick();
    chk("rg_idle_busrq", O_BUSRQn, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
